flash_cmd_sequencer: RTL and testbench
======================================

Name: flash_cmd_sequencer

Overview:
- Sequences JEDEC command bus cycles to the paired x8 Kickstart flash chips (high byte on FLASH_WR_n[1]/FLASH_RD_n[1], low byte on [0]).
- Supports word program, sector erase, chip erase and read/reset, then polls toggle bit DQ6 until the embedded algorithm completes.
- Sits between the CPU-side flash access decode and the flash pins; owns the pins whenever BUSY is high.

Parameters:
ADDR_W, 19, flash word-address width
SETUP_CYC, 1, CLK cycles address/data stable before the WR_n falling edge (1..15)
WE_CYC, 2, CLK cycles WR_n held low (1..15)
HOLD_CYC, 1, CLK cycles WR_n high after each write before the next cycle (1..15)
RD_CYC, 2, CLK cycles RD_n low per poll read; DQ is sampled in the last cycle (1..15)
TIMEOUT_W, 24, poll timeout counter width; timeout occurs at all-ones

Ports:
CLK  input  1  system clock
RESET_n  input  1  asynchronous active-low reset
CMD_VALID  input  1  command request
CMD_READY  output  1  high only in IDLE; command accepted when CMD_VALID && CMD_READY
CMD_OP  input  2  00 program, 01 sector erase, 10 chip erase, 11 read/reset
CMD_ADDR  input  ADDR_W  target word address (program) / sector address (erase)
CMD_DATA  input  16  program data
BUSY  output  1  high in any state other than IDLE
DONE  output  1  single-cycle completion pulse
ERROR  output  1  valid only with DONE; 1 = DQ5 fail or timeout
FLASH_ADDR  output  ADDR_W  flash word address
FLASH_DQ_OUT  output  16  write data
FLASH_DQ_OE  output  1  drive FLASH_DQ_OUT onto the bus
FLASH_DQ_IN  input  16  read data from the bus
FLASH_WR_n  output  2  per-byte write strobes, active low
FLASH_RD_n  output  2  per-byte read strobes, active low

Behaviour:
- Reset values (asynchronous, also applied mid-operation):
  - State IDLE, step 0, all counters 0.
  - FLASH_WR_n=2'b11, FLASH_RD_n=2'b11, FLASH_DQ_OE=0, FLASH_ADDR=0, FLASH_DQ_OUT=0.
  - DONE=0, ERROR=0, BUSY=0, CMD_READY=1.
  - A reset issued mid-write aborts with no further strobes.
- Command latching:
  - On accept, CMD_OP, CMD_ADDR and CMD_DATA are registered.
  - Inputs are ignored until the next IDLE.
  - The first strobe starts in the cycle after accept.
- Write sequences, as (addr, data) steps; both bytes are written together, so FLASH_WR_n = 2'b00 while active:
  - Program: (5555,AAAA) (2AAA,5555) (5555,A0A0) (ADDR,DATA).
  - Sector erase: (5555,AAAA) (2AAA,5555) (5555,8080) (5555,AAAA) (2AAA,5555) (ADDR,3030).
  - Chip erase: as sector erase, but the last step is (5555,1010).
  - Read/reset: single step (0,F0F0), then DONE with ERROR=0 and no poll.
- Write cycle FSM: WSETUP (SETUP_CYC) -> WPULSE (WE_CYC, WR_n low) -> WHOLD (HOLD_CYC).
  - FLASH_DQ_OE=1 and FLASH_ADDR/FLASH_DQ_OUT stay stable across all three states.
  - After the last step, go to POLL_RD (program/erase) or DONE (read/reset).
- Poll FSM, POLL_RD -> POLL_GAP:
  - POLL_RD: FLASH_DQ_OE=0, FLASH_RD_n=2'b00 for RD_CYC cycles; FLASH_DQ_IN is sampled in the last cycle.
  - POLL_GAP: 1 cycle with RD_n high.
  - Toggle = (bit14,bit6) of the current sample XOR the previous sample. The first read has no previous sample and counts as toggling.
  - If toggle==0 for both bytes -> DONE, ERROR=0.
  - If toggling and DQ5 (bit13 or bit5) is set on a toggling byte: perform one more read. Still toggling -> RECOVER, otherwise DONE with ERROR=0.
- Timeout:
  - The counter increments every poll-state cycle and is cleared on accept.
  - At all-ones -> RECOVER, which takes precedence over a simultaneous completion.
- RECOVER: one write cycle (0,F0F0), then DONE with ERROR=1.
- DONE state:
  - DONE=1 for 1 cycle, ERROR held for that cycle, then IDLE.
  - CMD_READY rises in the cycle after DONE.
- Width and wrap rules: the step index is 3 bits and never exceeds 5; per-state cycle counters are 4 bits and reload on each state entry.
- Exactly one of FLASH_WR_n or FLASH_RD_n may be active in any cycle; WR_n and RD_n are never both low.

Test Plan:
- Program: CMD_OP=00, ADDR=0x12345, DATA=0xBEEF, default params -> four write cycles with addresses 5555,2AAA,5555,12345 and data AAAA,5555,A0A0,BEEF. WR_n is low 2 cycles each, 4 cycles per write. Flash model toggles DQ6 for 3 reads then stable -> DONE with ERROR=0.
- Sector erase at ADDR=0x40000 -> six writes, the last being (40000,3030), then polling. Completion -> DONE, ERROR=0, BUSY low the cycle after DONE.
- DQ5 fail: model toggles DQ6 indefinitely with DQ5=1 on the low byte -> after the confirm read, a (0,F0F0) write is issued, then DONE with ERROR=1.
- Timeout with TIMEOUT_W=6 and the model toggling forever with DQ5=0 -> RECOVER after 63 poll cycles, DONE with ERROR=1.
- Handshake: hold CMD_VALID high continuously with changing CMD_DATA -> only the value present at accept is written. A second command is accepted no earlier than the cycle after DONE.
- Assert RESET_n low during WPULSE of step 2 -> WR_n=11, DQ_OE=0 and BUSY=0 immediately. After release, a read/reset command produces a single (0,F0F0) write and DONE with ERROR=0.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command-cycle sequencer for the paired x8 Kickstart flash: issues the unlock/command
// writes, then polls the DQ6 toggle bit (with DQ5 fail confirm and timeout) until the chip is done.
module flash_cmd_sequencer #(
    parameter int ADDR_W    = 19,
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RD_CYC    = 2,
    parameter int TIMEOUT_W = 24
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [15:0]       CMD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_W-1:0] FLASH_ADDR,
    output logic [15:0]       FLASH_DQ_OUT,
    output logic              FLASH_DQ_OE,
    input  logic [15:0]       FLASH_DQ_IN,
    output logic [1:0]        FLASH_WR_n,
    output logic [1:0]        FLASH_RD_n
);
    localparam logic [1:0] OP_PROG  = 2'b00;
    localparam logic [1:0] OP_SECT  = 2'b01;
    localparam logic [1:0] OP_RESET = 2'b11;
    localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WE_L     = 4'(WE_CYC - 1);
    localparam logic [3:0] HOLD_L   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RD_L     = 4'(RD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WSETUP, S_WPULSE, S_WHOLD, S_POLL_RD, S_POLL_GAP, S_RECOVER, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_op;
    logic [ADDR_W-1:0]     r_addr;
    logic [15:0]           r_data;
    logic [2:0]            r_step;
    logic [3:0]            r_cnt;
    logic [TIMEOUT_W-1:0]  r_tmo;
    logic [1:0]            r_prev;
    logic                  r_first, r_confirm, r_tog, r_fail, r_rec, r_err;

    logic [2:0]            w_last_step;
    logic                  w_wr_last;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [15:0]           w_wr_data;
    logic [1:0]            w_tog;
    logic                  w_fail;
    logic [TIMEOUT_W-1:0]  w_tmo_inc;
    logic                  w_tmo_hit;
    logic                  w_unused_dq;

    // Command table; recovery and read/reset both issue the (0,F0F0) reset write.
    always_comb begin
        w_last_step = 3'd5;
        if (r_op == OP_PROG)
            w_last_step = 3'd3;
        else if (r_op == OP_RESET)
            w_last_step = 3'd0;
        w_wr_addr = ADDR_W'(16'h5555);
        w_wr_data = 16'hAAAA;
        if (r_rec || r_op == OP_RESET) begin
            w_wr_addr = '0;
            w_wr_data = 16'hF0F0;
        end else begin
            case (r_step)
                3'd0: ;
                3'd1: begin w_wr_addr = ADDR_W'(16'h2AAA); w_wr_data = 16'h5555; end
                3'd2: w_wr_data = (r_op == OP_PROG) ? 16'hA0A0 : 16'h8080;
                3'd3: if (r_op == OP_PROG) begin w_wr_addr = r_addr; w_wr_data = r_data; end
                3'd4: begin w_wr_addr = ADDR_W'(16'h2AAA); w_wr_data = 16'h5555; end
                default: begin
                    if (r_op == OP_SECT) begin
                        w_wr_addr = r_addr;
                        w_wr_data = 16'h3030;
                    end else begin
                        w_wr_data = 16'h1010;
                    end
                end
            endcase
        end
    end

    assign w_wr_last   = r_rec || (r_step == w_last_step);
    // First read has nothing to compare against, so it counts as toggling on both bytes.
    assign w_tog       = r_first ? 2'b11 : {FLASH_DQ_IN[14] ^ r_prev[1], FLASH_DQ_IN[6] ^ r_prev[0]};
    assign w_fail      = (w_tog[1] & FLASH_DQ_IN[13]) | (w_tog[0] & FLASH_DQ_IN[5]);
    assign w_tmo_inc   = r_tmo + TIMEOUT_W'(1);
    assign w_tmo_hit   = &w_tmo_inc;
    assign w_unused_dq = ^{FLASH_DQ_IN[15], FLASH_DQ_IN[12:7], FLASH_DQ_IN[4:0]};

    always_comb begin
        w_next       = r_state;
        CMD_READY    = 1'b0;
        BUSY         = 1'b1;
        DONE         = 1'b0;
        ERROR        = 1'b0;
        FLASH_ADDR   = '0;
        FLASH_DQ_OUT = '0;
        FLASH_DQ_OE  = 1'b0;
        FLASH_WR_n   = 2'b11;
        FLASH_RD_n   = 2'b11;
        case (r_state)
            S_IDLE: begin
                CMD_READY = 1'b1;
                BUSY      = 1'b0;
                if (CMD_VALID) w_next = S_WSETUP;
            end
            S_WSETUP, S_WPULSE, S_WHOLD: begin
                FLASH_ADDR   = w_wr_addr;
                FLASH_DQ_OUT = w_wr_data;
                FLASH_DQ_OE  = 1'b1;
                if (r_state == S_WSETUP) begin
                    if (r_cnt == SETUP_L) w_next = S_WPULSE;
                end else if (r_state == S_WPULSE) begin
                    FLASH_WR_n = 2'b00;
                    if (r_cnt == WE_L) w_next = S_WHOLD;
                end else if (r_cnt == HOLD_L) begin
                    if (r_rec || r_op == OP_RESET) w_next = S_DONE;
                    else if (w_wr_last)            w_next = S_POLL_RD;
                    else                           w_next = S_WSETUP;
                end
            end
            S_POLL_RD: begin
                FLASH_ADDR = r_addr;
                FLASH_RD_n = 2'b00;
                if (w_tmo_hit)          w_next = S_RECOVER;
                else if (r_cnt == RD_L) w_next = S_POLL_GAP;
            end
            S_POLL_GAP: begin
                FLASH_ADDR = r_addr;
                if (w_tmo_hit)      w_next = S_RECOVER;
                else if (!r_tog)    w_next = S_DONE;
                else if (r_confirm) w_next = S_RECOVER;
                else                w_next = S_POLL_RD;
            end
            S_RECOVER: w_next = S_WSETUP;
            S_DONE: begin
                DONE   = 1'b1;
                ERROR  = r_err;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_step    <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_prev    <= '0;
            r_first   <= 1'b0;
            r_confirm <= 1'b0;
            r_tog     <= 1'b0;
            r_fail    <= 1'b0;
            r_rec     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
            case (r_state)
                S_IDLE: if (CMD_VALID) begin
                    r_op      <= CMD_OP;
                    r_addr    <= CMD_ADDR;
                    r_data    <= CMD_DATA;
                    r_step    <= '0;
                    r_tmo     <= '0;
                    r_first   <= 1'b1;
                    r_confirm <= 1'b0;
                    r_rec     <= 1'b0;
                    r_err     <= 1'b0;
                end
                S_WHOLD: if (r_cnt == HOLD_L && !w_wr_last) r_step <= r_step + 3'd1;
                S_POLL_RD: begin
                    r_tmo <= w_tmo_inc;
                    if (r_cnt == RD_L) begin
                        r_prev  <= {FLASH_DQ_IN[14], FLASH_DQ_IN[6]};
                        r_first <= 1'b0;
                        r_tog   <= |w_tog;
                        r_fail  <= w_fail;
                    end
                end
                S_POLL_GAP: begin
                    r_tmo <= w_tmo_inc;
                    if (r_tog && r_fail) r_confirm <= 1'b1;
                end
                S_RECOVER: begin
                    r_rec <= 1'b1;
                    r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: command table with a write scoreboard and toggle-bit flash
// models, plus handshake, mid-write reset and timeout (TIMEOUT_W=6 instance) sequences.
module tb_flash_cmd_sequencer;
    localparam int AW = 19;

    typedef struct packed {
        logic [18:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [18:0] addr;
        logic [15:0] data;
        int          mode;
        logic        err;
        int          nwr;
        int          nrd;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RESET_n = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          t_valid = 1'b0;
    logic [1:0]    CMD_OP = '0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [15:0]   CMD_DATA = '0;
    logic          CMD_READY, BUSY, DONE, ERROR, FLASH_DQ_OE;
    logic [AW-1:0] FLASH_ADDR;
    logic [15:0]   FLASH_DQ_OUT, FLASH_DQ_IN;
    logic [1:0]    FLASH_WR_n, FLASH_RD_n;
    logic          t_ready, t_busy, t_done, t_err, t_oe;
    logic [AW-1:0] t_addr;
    logic [15:0]   t_dq_out, t_dq_in;
    logic [1:0]    t_wr, t_rd;

    int  checks = 0, failures = 0;
    int  rd_cnt = 0, wr_cnt = 0, lat_cnt = 0, first_lat = 0, t_rd_cnt = 0, mode = 0;
    logic lat_armed = 1'b0;
    wr_t sb[$];
    vec_t vec[6];
    logic m_t, t_t;

    always #5 CLK = ~CLK;

    // Mode 0: DQ6 toggles for 3 reads then holds; mode 1: toggles forever with low-byte DQ5 set.
    assign m_t = (mode == 0) ? ((rd_cnt < 3) ? rd_cnt[0] : 1'b0) : rd_cnt[0];
    assign FLASH_DQ_IN = {1'b0, m_t, 1'b0, 5'b0, 1'b0, m_t, (mode == 1), 5'b0};
    assign t_t = t_rd_cnt[0];
    assign t_dq_in = {1'b0, t_t, 6'b0, 1'b0, t_t, 6'b0};

    flash_cmd_sequencer dut (
        .CLK(CLK), .RESET_n(RESET_n), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .BUSY(BUSY), .DONE(DONE),
        .ERROR(ERROR), .FLASH_ADDR(FLASH_ADDR), .FLASH_DQ_OUT(FLASH_DQ_OUT),
        .FLASH_DQ_OE(FLASH_DQ_OE), .FLASH_DQ_IN(FLASH_DQ_IN), .FLASH_WR_n(FLASH_WR_n),
        .FLASH_RD_n(FLASH_RD_n)
    );

    flash_cmd_sequencer #(.TIMEOUT_W(6)) dut_t (
        .CLK(CLK), .RESET_n(RESET_n), .CMD_VALID(t_valid), .CMD_READY(t_ready),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .BUSY(t_busy), .DONE(t_done),
        .ERROR(t_err), .FLASH_ADDR(t_addr), .FLASH_DQ_OUT(t_dq_out),
        .FLASH_DQ_OE(t_oe), .FLASH_DQ_IN(t_dq_in), .FLASH_WR_n(t_wr),
        .FLASH_RD_n(t_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [1:0] op, input logic [18:0] a, input logic [15:0] d,
                            input logic fail);
        case (op)
            2'b00: begin
                sb.push_back({19'h05555, 16'hAAAA}); sb.push_back({19'h02AAA, 16'h5555});
                sb.push_back({19'h05555, 16'hA0A0}); sb.push_back({a, d});
            end
            2'b01, 2'b10: begin
                sb.push_back({19'h05555, 16'hAAAA}); sb.push_back({19'h02AAA, 16'h5555});
                sb.push_back({19'h05555, 16'h8080}); sb.push_back({19'h05555, 16'hAAAA});
                sb.push_back({19'h02AAA, 16'h5555});
                if (op == 2'b01) sb.push_back({a, 16'h3030});
                else             sb.push_back({19'h05555, 16'h1010});
            end
            default: sb.push_back({19'h00000, 16'hF0F0});
        endcase
        if (fail) sb.push_back({19'h00000, 16'hF0F0});
    endtask

    task automatic send(input logic [1:0] op, input logic [18:0] a, input logic [15:0] d,
                        input logic fail);
        @(posedge CLK); #1;
        CMD_OP = op; CMD_ADDR = a; CMD_DATA = d; CMD_VALID = 1'b1;
        push_seq(op, a, d, fail);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(output logic seen, output logic err);
        seen = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) begin seen = 1'b1; err = ERROR; end
        end
    endtask

    // Write scoreboard, strobe timing and the read counters feeding the flash models.
    task automatic monitor();
        logic [1:0] prev_wr, prev_rd, t_prev_rd;
        int low_cnt;
        wr_t e;
        prev_wr = 2'b11; prev_rd = 2'b11; t_prev_rd = 2'b11; low_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RESET_n) begin
                prev_wr = 2'b11; prev_rd = 2'b11; t_prev_rd = 2'b11; low_cnt = 0;
            end else begin
                if (BUSY) chk("wr_rd_excl", 32'(FLASH_WR_n == 2'b00 && FLASH_RD_n == 2'b00), 32'd0);
                if (lat_armed) lat_cnt++;
                if (FLASH_WR_n == 2'b00) begin
                    if (prev_wr != 2'b00) begin
                        wr_cnt++;
                        if (lat_armed) begin first_lat = lat_cnt; lat_armed = 1'b0; end
                        if (sb.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_write addr=%0h data=%0h expected=none",
                                     FLASH_ADDR, FLASH_DQ_OUT);
                        end else begin
                            e = sb.pop_front();
                            chk("wr_addr", 32'(FLASH_ADDR), 32'(e.a));
                            chk("wr_data", 32'(FLASH_DQ_OUT), 32'(e.d));
                        end
                        chk("wr_oe", 32'(FLASH_DQ_OE), 32'd1);
                        low_cnt = 0;
                    end
                    low_cnt++;
                end else if (prev_wr == 2'b00) begin
                    chk("wr_low_cycles", 32'(low_cnt), 32'd2);
                end
                if (FLASH_RD_n == 2'b11 && prev_rd == 2'b00) rd_cnt++;
                if (t_rd == 2'b11 && t_prev_rd == 2'b00) t_rd_cnt++;
                if (CMD_VALID && CMD_READY) begin
                    rd_cnt = 0; wr_cnt = 0; lat_cnt = 0; lat_armed = 1'b1;
                end
                prev_wr = FLASH_WR_n; prev_rd = FLASH_RD_n; t_prev_rd = t_rd;
            end
        end
    endtask

    initial begin
        logic seen, err, hit;
        int n_acc, n_done, done1_cyc, acc2_cyc, t_nwr, gap;
        logic [1:0] t_prev;

        vec[0] = '{"prog",      2'b00, 19'h12345, 16'hBEEF, 0, 1'b0, 4, 4};
        vec[1] = '{"sect",      2'b01, 19'h40000, 16'h0000, 0, 1'b0, 6, 4};
        vec[2] = '{"chip",      2'b10, 19'h00000, 16'h0000, 0, 1'b0, 6, 4};
        vec[3] = '{"rdreset",   2'b11, 19'h00000, 16'h0000, 0, 1'b0, 1, 0};
        vec[4] = '{"prog_fail", 2'b00, 19'h00777, 16'h1234, 1, 1'b1, 5, 2};
        vec[5] = '{"sect_fail", 2'b01, 19'h7FFFF, 16'h0000, 1, 1'b1, 7, 2};

        fork monitor(); join_none
        repeat (3) @(posedge CLK);
        #1 RESET_n = 1'b1;
        @(negedge CLK);
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done_err", 32'({DONE, ERROR}), 32'd0);
        chk("rst_strobes", 32'({FLASH_WR_n, FLASH_RD_n}), 32'hF);
        chk("rst_bus", 32'({FLASH_DQ_OE, FLASH_ADDR, FLASH_DQ_OUT}), 32'd0);

        for (int i = 0; i < 6; i++) begin
            mode = vec[i].mode;
            send(vec[i].op, vec[i].addr, vec[i].data, vec[i].err);
            wait_done(seen, err);
            chk({vec[i].name, "_done"}, 32'(seen), 32'd1);
            chk({vec[i].name, "_err"}, 32'(err), 32'(vec[i].err));
            chk({vec[i].name, "_nwr"}, 32'(wr_cnt), 32'(vec[i].nwr));
            chk({vec[i].name, "_nrd"}, 32'(rd_cnt), 32'(vec[i].nrd));
            chk({vec[i].name, "_lat"}, 32'(first_lat), 32'd2);
            @(negedge CLK);
            chk({vec[i].name, "_busy_after"}, 32'(BUSY), 32'd0);
            chk({vec[i].name, "_ready_after"}, 32'(CMD_READY), 32'd1);
            chk({vec[i].name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        end

        // CMD_VALID held high with data changing every cycle across two commands.
        mode = 0;
        @(posedge CLK); #1;
        CMD_OP = 2'b00; CMD_ADDR = 19'h00100; CMD_DATA = 16'h1000; CMD_VALID = 1'b1;
        n_acc = 0; n_done = 0; done1_cyc = 0; acc2_cyc = 0;
        for (int c = 0; c < 400 && n_done < 2; c++) begin
            @(negedge CLK);
            if (CMD_VALID && CMD_READY) begin
                push_seq(CMD_OP, CMD_ADDR, CMD_DATA, 1'b0);
                n_acc++;
                if (n_acc == 2) acc2_cyc = c;
            end
            if (DONE) begin
                n_done++;
                if (n_done == 1) done1_cyc = c;
                chk("hs_err", 32'(ERROR), 32'd0);
                chk("hs_ready_in_done", 32'(CMD_READY), 32'd0);
            end
            @(posedge CLK); #1;
            if (n_acc == 2) CMD_VALID = 1'b0;
            else            CMD_DATA = CMD_DATA + 16'h0101;
        end
        chk("hs_n_done", 32'(n_done), 32'd2);
        chk("hs_n_acc", 32'(n_acc), 32'd2);
        chk("hs_acc2_gap", 32'(acc2_cyc - done1_cyc), 32'd1);
        chk("hs_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the WR pulse of step 2.
        send(2'b00, 19'h20000, 16'h5A5A, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge CLK);
            if (wr_cnt == 3 && FLASH_WR_n == 2'b00) hit = 1'b1;
        end
        chk("rst_mid_reached", 32'(hit), 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(FLASH_WR_n), 32'h3);
        chk("rst_mid_oe", 32'(FLASH_DQ_OE), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_ready", 32'(CMD_READY), 32'd1);
        sb.delete();
        repeat (2) @(negedge CLK);
        #2 RESET_n = 1'b1;
        repeat (4) @(negedge CLK);
        chk("rst_mid_no_more_wr", 32'(wr_cnt), 32'd3);
        chk("rst_mid_idle", 32'(BUSY), 32'd0);
        send(2'b11, 19'h00000, 16'h0000, 1'b0);
        wait_done(seen, err);
        chk("post_rst_done", 32'(seen), 32'd1);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_nwr", 32'(wr_cnt), 32'd1);
        chk("post_rst_sb", 32'(sb.size()), 32'd0);

        // Timeout on the TIMEOUT_W=6 instance: flash toggles forever with DQ5 clear.
        @(negedge CLK);
        chk("tmo_ready", 32'(t_ready), 32'd1);
        @(posedge CLK); #1;
        CMD_OP = 2'b00; CMD_ADDR = 19'h00055; CMD_DATA = 16'h1111; t_valid = 1'b1;
        @(posedge CLK); #1;
        t_valid = 1'b0;
        t_nwr = 0; gap = 0; t_prev = 2'b11; seen = 1'b0; err = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge CLK);
            if (t_wr == 2'b00 && t_prev != 2'b00) begin
                t_nwr++;
                if (t_nwr == 5) begin
                    chk("tmo_rec_addr", 32'(t_addr), 32'd0);
                    chk("tmo_rec_data", 32'(t_dq_out), 32'hF0F0);
                end
            end
            if (t_busy && !t_oe && t_nwr == 4) gap++;
            if (t_done) begin seen = 1'b1; err = t_err; end
            t_prev = t_wr;
        end
        chk("tmo_done", 32'(seen), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_nwr", 32'(t_nwr), 32'd5);
        chk("tmo_poll_plus_recover_cycles", 32'(gap), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
